// File: rtl/layer_featuremap_packer.sv
// Purpose: channel packer. It collects NUM_CH serial channel samples per pixel and emits
//          one packed pixel word, with lane i = channel i. The pixel counter flags the
//          last pixel of each frame.
// Ports:
//   Clk        clock, rising edge
//   Rst        synchronous reset, active-high
//   data_in    one channel sample, channel 0 first
//   valid_in   data_in valid
//   ready_out  packer can accept data_in (combinational, depends on ready_in)
//   data_out   packed pixel, lane i = bits [DATA_WIDTH*i +: DATA_WIDTH]
//   valid_out  data_out valid
//   ready_in   downstream accepts data_out
//   last_out   data_out is the last pixel of the frame
module layer_featuremap_packer #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_CH     = 16,
   parameter int unsigned IMG_SIZE   = 208
) (
   input  logic                         Clk,
   input  logic                         Rst,
   input  logic [DATA_WIDTH-1:0]        data_in,
   input  logic                         valid_in,
   output logic                         ready_out,
   output logic [DATA_WIDTH*NUM_CH-1:0] data_out,
   output logic                         valid_out,
   input  logic                         ready_in,
   output logic                         last_out
);

   localparam int unsigned DATA_OUT_WIDTH = DATA_WIDTH * NUM_CH;
   localparam int unsigned FRAME_PIX      = IMG_SIZE * IMG_SIZE;
   localparam int unsigned CH_W           = $clog2(NUM_CH);
   localparam int unsigned PIX_W          = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } asm_state_e;

   asm_state_e                asm_state_q, asm_state_d;
   logic [CH_W-1:0]           ch_cnt_q, ch_cnt_d;
   logic [PIX_W-1:0]          pix_cnt_q, pix_cnt_d;
   logic [DATA_OUT_WIDTH-1:0] asm_q, asm_d;
   logic [DATA_OUT_WIDTH-1:0] data_out_q, data_out_d;
   logic                      valid_out_q, valid_out_d;
   logic                      last_out_q, last_out_d;

   logic out_free;
   logic accept;
   logic xfer;
   logic last_ch;

   // Handshake terms; ready_in feeds ready_out combinationally so a held word never costs a bubble
   always_comb begin
      out_free  = !valid_out_q || ready_in;
      ready_out = (asm_state_q == FILL) || out_free;
      accept    = valid_in && ready_out;
      xfer      = (asm_state_q == FULL) && out_free;
      last_ch   = (ch_cnt_q == CH_W'(NUM_CH - 1));
   end

   // Assembly FSM, lane writes and output register next-state
   always_comb begin
      asm_state_d = asm_state_q;
      ch_cnt_d    = ch_cnt_q;
      pix_cnt_d   = pix_cnt_q;
      asm_d       = asm_q;
      data_out_d  = data_out_q;
      valid_out_d = valid_out_q;
      last_out_d  = last_out_q;

      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (accept && (ch_cnt_q == CH_W'(i))) begin
            asm_d[i*DATA_WIDTH +: DATA_WIDTH] = data_in;
         end
      end

      if (accept) begin
         ch_cnt_d = last_ch ? '0 : ch_cnt_q + CH_W'(1);
      end

      case (asm_state_q)
         FILL: begin
            if (accept && last_ch) begin
               asm_state_d = FULL;
            end
         end
         FULL: begin
            // While full, the only beat that can be accepted is channel 0, and only alongside a transfer
            if (xfer) begin
               asm_state_d = FILL;
            end
         end
         default: asm_state_d = FILL;
      endcase

      // Transfer copies the pre-edge assembly word, so a same-cycle lane-0 write cannot leak in
      if (xfer) begin
         data_out_d  = asm_q;
         valid_out_d = 1'b1;
         last_out_d  = (pix_cnt_q == PIX_W'(FRAME_PIX - 1));
         pix_cnt_d   = (pix_cnt_q == PIX_W'(FRAME_PIX - 1)) ? '0 : pix_cnt_q + PIX_W'(1);
      end else if (ready_in) begin
         valid_out_d = 1'b0;
      end
   end

   // State registers
   always_ff @(posedge Clk) begin
      if (Rst) begin
         asm_state_q <= FILL;
         ch_cnt_q    <= '0;
         pix_cnt_q   <= '0;
         asm_q       <= '0;
         data_out_q  <= '0;
         valid_out_q <= 1'b0;
         last_out_q  <= 1'b0;
      end else begin
         asm_state_q <= asm_state_d;
         ch_cnt_q    <= ch_cnt_d;
         pix_cnt_q   <= pix_cnt_d;
         asm_q       <= asm_d;
         data_out_q  <= data_out_d;
         valid_out_q <= valid_out_d;
         last_out_q  <= last_out_d;
      end
   end

   assign data_out  = data_out_q;
   assign valid_out = valid_out_q;
   assign last_out  = last_out_q;

endmodule

// File: tb/tb_layer_featuremap_packer.sv
// Purpose: self-checking bench for layer_featuremap_packer. Two instances share the inputs:
//          the default one (IMG_SIZE=208) and a small-frame one (IMG_SIZE=4) for last_out wrap.
// Ports: none (top-level bench).
module tb_layer_featuremap_packer;

   localparam int unsigned DW  = 32;
   localparam int unsigned NCH = 16;
   localparam int unsigned OW  = DW * NCH;

   logic          Clk = 1'b0;
   logic          Rst = 1'b1;
   logic [DW-1:0] data_in = '0;
   logic          valid_in = 1'b0;
   logic          ready_in = 1'b1;

   logic          ready_out, valid_out, last_out;
   logic [OW-1:0] data_out;
   logic          ready_out4, valid_out4, last_out4;
   logic [OW-1:0] data_out4;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int stalls = 0;
   int hold_viol = 0;

   logic [DW-1:0] sent_q[$];   // beats accepted since the last reset, in order
   logic [OW-1:0] obs_w[$];
   logic          obs_l[$];
   int            obs_c[$];
   logic [OW-1:0] obs_w4[$];
   logic          obs_l4[$];

   always #5 Clk = ~Clk;

   layer_featuremap_packer dut (
      .Clk(Clk), .Rst(Rst), .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out),
      .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in), .last_out(last_out)
   );

   layer_featuremap_packer #(.IMG_SIZE(4)) dut4 (
      .Clk(Clk), .Rst(Rst), .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out4),
      .data_out(data_out4), .valid_out(valid_out4), .ready_in(ready_in), .last_out(last_out4)
   );

   // Records each new output word (a transfer) and any change of a stalled word
   always @(posedge Clk) begin : mon
      logic          pv, pr, prst, pv4;
      logic [OW-1:0] pd;
      cyc++;
      pv   = valid_out;
      pr   = ready_in;
      prst = Rst;
      pd   = data_out;
      pv4  = valid_out4;
      #1;
      if (!prst) begin
         if (valid_out && (!pv || pr)) begin
            obs_w.push_back(data_out);
            obs_l.push_back(last_out);
            obs_c.push_back(cyc);
         end else if (pv && !pr && (data_out !== pd)) begin
            hold_viol++;
         end
         if (valid_out4 && (!pv4 || pr)) begin
            obs_w4.push_back(data_out4);
            obs_l4.push_back(last_out4);
         end
      end
   end

   // Reference packing: word n is the n-th group of NCH accepted beats, channel i in lane i
   function automatic logic [OW-1:0] exp_word(input int n);
      logic [OW-1:0] w;
      w = '0;
      for (int i = 0; i < NCH; i++) w[DW*i +: DW] = sent_q[NCH*n + i];
      return w;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge Clk);
         valid_in = 1'b0;
      end
   endtask

   task automatic send_beat(input logic [DW-1:0] d);
      int w;
      w = 0;
      @(negedge Clk);
      data_in  = d;
      valid_in = 1'b1;
      #1;
      while (!ready_out && w < 300) begin
         stalls++;
         @(negedge Clk);
         #1;
         w++;
      end
      total++;
      if (!ready_out) begin
         bad++;
         $display("FAIL send_beat_timeout: ready_out=%0b required 1", ready_out);
         valid_in = 1'b0;
      end else begin
         @(posedge Clk);
         sent_q.push_back(d);
      end
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Rst = 1'b1;
      valid_in = 1'b0;
      ready_in = 1'b1;
      @(negedge Clk);
      Rst = 1'b0;
      sent_q.delete(); obs_w.delete(); obs_l.delete(); obs_c.delete();
      obs_w4.delete(); obs_l4.delete();
      hold_viol = 0;
      stalls = 0;
   endtask

   task automatic test_reset();
      Rst = 1'b1;
      repeat (2) @(negedge Clk);
      total += 6;
      if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", valid_out); end
      if (last_out !== 1'b0) begin bad++; $display("FAIL reset_last: got %0b want 0", last_out); end
      if (data_out !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", data_out); end
      if (ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b want 1", ready_out); end
      if (ready_out4 !== 1'b1) begin bad++; $display("FAIL reset_ready4: got %0b want 1", ready_out4); end
      if (valid_out4 !== 1'b0) begin bad++; $display("FAIL reset_valid4: got %0b want 0", valid_out4); end
      do_reset();
   endtask

   task automatic test_single_pixel();
      logic [OW-1:0] w;
      do_reset();
      for (int i = 0; i < NCH; i++) send_beat(32'h1000_0000 + 32'(i));
      for (int i = 0; i < NCH; i++) w[DW*i +: DW] = 32'h1000_0000 + 32'(i);
      @(negedge Clk);
      valid_in = 1'b0;
      total++;
      if (valid_out !== 1'b0) begin bad++; $display("FAIL t1_early_valid: got %0b want 0", valid_out); end
      @(negedge Clk);
      total += 3;
      if (valid_out !== 1'b1) begin bad++; $display("FAIL t1_valid: got %0b want 1", valid_out); end
      if (data_out !== w) begin bad++; $display("FAIL t1_data: got %h want %h", data_out, w); end
      if (last_out !== 1'b0) begin bad++; $display("FAIL t1_last: got %0b want 0", last_out); end
      @(negedge Clk);
      total++;
      if (valid_out !== 1'b0) begin bad++; $display("FAIL t1_pulse: got %0b want 0", valid_out); end
   endtask

   task automatic test_backpressure();
      int rel;
      int w;
      do_reset();
      @(negedge Clk);
      ready_in = 1'b0;
      rel = 0;
      fork
         begin
            for (int i = 0; i < 40; i++) send_beat($urandom);
         end
         begin
            w = 0;
            while (sent_q.size() < 32 && w < 400) begin @(negedge Clk); w++; end
            #2;
            for (int k = 0; k < 3; k++) begin
               @(negedge Clk);
               #2;
               total += 4;
               if (ready_out !== 1'b0) begin bad++; $display("FAIL t2_ready: got %0b want 0", ready_out); end
               if (valid_out !== 1'b1) begin bad++; $display("FAIL t2_hold_valid: got %0b want 1", valid_out); end
               if (data_out !== exp_word(0)) begin bad++; $display("FAIL t2_hold_data: got %h want %h", data_out, exp_word(0)); end
               if (sent_q.size() != 32) begin bad++; $display("FAIL t2_stall_count: got %0d want 32", sent_q.size()); end
            end
            @(negedge Clk);
            ready_in = 1'b1;
            rel = cyc;
         end
      join
      idle(30);
      total += 2;
      if (sent_q.size() != 40) begin bad++; $display("FAIL t2_sent: got %0d want 40", sent_q.size()); end
      if (obs_w.size() != 2) begin bad++; $display("FAIL t2_words: got %0d want 2", obs_w.size()); end
      for (int n = 0; n < obs_w.size() && n < 2; n++) begin
         total++;
         if (obs_w[n] !== exp_word(n)) begin bad++; $display("FAIL t2_word%0d: got %h want %h", n, obs_w[n], exp_word(n)); end
      end
      if (obs_c.size() >= 2) begin
         total++;
         if (obs_c[1] != rel + 1) begin bad++; $display("FAIL t2_release_latency: got %0d want %0d", obs_c[1], rel + 1); end
      end
      total++;
      if (hold_viol != 0) begin bad++; $display("FAIL t2_hold_stable: got %0d want 0", hold_viol); end
   endtask

   task automatic test_bubbles();
      int g;
      do_reset();
      for (int i = 0; i < 48; i++) begin
         g = 0;
         while ($urandom_range(1) == 1 && g < 4) begin idle(1); g++; end
         send_beat($urandom);
      end
      idle(30);
      total++;
      if (obs_w.size() != 3) begin bad++; $display("FAIL t3_words: got %0d want 3", obs_w.size()); end
      for (int n = 0; n < obs_w.size() && n < 3; n++) begin
         total += 2;
         if (obs_w[n] !== exp_word(n)) begin bad++; $display("FAIL t3_word%0d: got %h want %h", n, obs_w[n], exp_word(n)); end
         if (obs_l[n] !== 1'b0) begin bad++; $display("FAIL t3_last%0d: got %0b want 0", n, obs_l[n]); end
      end
   endtask

   task automatic test_random_backpressure();
      bit done;
      int g;
      do_reset();
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 96; i++) begin
               g = 0;
               while ($urandom_range(3) == 0 && g < 3) begin idle(1); g++; end
               send_beat($urandom);
            end
            done = 1'b1;
         end
         begin
            for (int k = 0; k < 5000 && !done; k++) begin
               @(negedge Clk);
               ready_in = ($urandom_range(2) != 0);
            end
         end
      join
      @(negedge Clk);
      ready_in = 1'b1;
      idle(40);
      total += 2;
      if (obs_w.size() != 6) begin bad++; $display("FAIL rbp_words: got %0d want 6", obs_w.size()); end
      if (hold_viol != 0) begin bad++; $display("FAIL rbp_hold_stable: got %0d want 0", hold_viol); end
      for (int n = 0; n < obs_w.size() && n < 6; n++) begin
         total++;
         if (obs_w[n] !== exp_word(n)) begin bad++; $display("FAIL rbp_word%0d: got %h want %h", n, obs_w[n], exp_word(n)); end
      end
   endtask

   task automatic test_frame_wrap();
      logic want;
      do_reset();
      for (int i = 0; i < 17 * NCH; i++) send_beat($urandom);
      idle(30);
      total += 2;
      if (obs_w4.size() != 17) begin bad++; $display("FAIL t4_words: got %0d want 17", obs_w4.size()); end
      if (obs_w.size() != 17) begin bad++; $display("FAIL t4_words_big: got %0d want 17", obs_w.size()); end
      for (int n = 0; n < obs_w4.size() && n < 17; n++) begin
         want = (n % 16 == 15);
         total += 2;
         if (obs_l4[n] !== want) begin bad++; $display("FAIL t4_last%0d: got %0b want %0b", n, obs_l4[n], want); end
         if (obs_w4[n] !== exp_word(n)) begin bad++; $display("FAIL t4_word%0d: got %h want %h", n, obs_w4[n], exp_word(n)); end
      end
      for (int n = 0; n < obs_l.size() && n < 17; n++) begin
         total++;
         if (obs_l[n] !== 1'b0) begin bad++; $display("FAIL t4_last_big%0d: got %0b want 0", n, obs_l[n]); end
      end
   endtask

   task automatic test_reset_mid_pixel();
      logic [OW-1:0] w;
      do_reset();
      for (int i = 0; i < 7; i++) send_beat($urandom);
      @(negedge Clk);
      valid_in = 1'b0;
      Rst = 1'b1;
      total++;
      if (obs_w.size() != 0) begin bad++; $display("FAIL t5_early_out: got %0d want 0", obs_w.size()); end
      @(negedge Clk);
      Rst = 1'b0;
      total += 2;
      if (valid_out !== 1'b0) begin bad++; $display("FAIL t5_valid_in_reset: got %0b want 0", valid_out); end
      if (ready_out !== 1'b1) begin bad++; $display("FAIL t5_ready_after_reset: got %0b want 1", ready_out); end
      sent_q.delete(); obs_w.delete(); obs_l.delete(); obs_c.delete();
      obs_w4.delete(); obs_l4.delete();
      for (int i = 0; i < NCH; i++) send_beat(32'hA0 + 32'(i));
      for (int i = 0; i < NCH; i++) w[DW*i +: DW] = 32'hA0 + 32'(i);
      idle(10);
      total++;
      if (obs_w.size() != 1) begin bad++; $display("FAIL t5_words: got %0d want 1", obs_w.size()); end
      if (obs_w.size() >= 1) begin
         total++;
         if (obs_w[0] !== w) begin bad++; $display("FAIL t5_word: got %h want %h", obs_w[0], w); end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 4 * NCH; i++) send_beat($urandom);
      idle(30);
      total += 2;
      if (stalls != 0) begin bad++; $display("FAIL t6_ready_drop: got %0d want 0", stalls); end
      if (obs_w.size() != 4) begin bad++; $display("FAIL t6_words: got %0d want 4", obs_w.size()); end
      for (int n = 0; n < obs_w.size() && n < 4; n++) begin
         total++;
         if (obs_w[n] !== exp_word(n)) begin bad++; $display("FAIL t6_word%0d: got %h want %h", n, obs_w[n], exp_word(n)); end
      end
      for (int n = 1; n < obs_c.size() && n < 4; n++) begin
         total++;
         if (obs_c[n] - obs_c[n-1] != NCH) begin
            bad++;
            $display("FAIL t6_spacing%0d: got %0d want %0d", n, obs_c[n] - obs_c[n-1], NCH);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_pixel();
      test_backpressure();
      test_bubbles();
      test_random_backpressure();
      test_frame_wrap();
      test_reset_mid_pixel();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
